// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the board-switch debouncer.
package switch_debounce_pkg;
  localparam int SW_WIDTH                 = 16;
  localparam int SW_STABLE_CYCLES_DEFAULT = 1000000;
  localparam int SW_STABLE_CYCLES_SIM     = 4;

  // Per-bit edge event raised one cycle after the accepted level moves.
  typedef struct packed {
    logic rise;
    logic fall;
  } sw_edge_t;

  // Counter width: holds 0..n-1 without wrapping.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle between board pins, the debouncer and the switch read port.
interface switch_debounce_if
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    input  sw_raw,
    output sw_stable, sw_rise, sw_fall, sw_changed
  );

  modport slave (
    output sw_raw,
    input  sw_stable, sw_rise, sw_fall, sw_changed
  );
endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, accepted level, edge flags.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
  input  logic     switclk,
  input  logic     switrst,
  input  logic     raw_i,
  output logic     stable_o,
  output sw_edge_t evt_o,
  output logic     chg_o
);
  localparam int            CW      = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  sw_edge_t      evt_q;

  // Any cycle where sync2 matches the accepted level restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      evt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      evt_q.rise   <= stable_q & ~stable_dly_q;
      evt_q.fall   <= ~stable_q & stable_dly_q;
    end
  end

  assign stable_o = stable_q;
  assign evt_o    = evt_q;
  // Pre-register change term so the top's sw_changed lines up with rise/fall.
  assign chg_o    = stable_q ^ stable_dly_q;
endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH board switches; one debounce_bit per switch plus a shared change flag.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEFAULT
) (
  input  logic             switclk,
  input  logic             switrst,
  switch_debounce_if.master sw
);
  logic [WIDTH-1:0] stable, rise, fall, chg;
  sw_edge_t [WIDTH-1:0] evt;
  logic changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
      .switclk  (switclk),
      .switrst  (switrst),
      .raw_i    (sw.sw_raw[i]),
      .stable_o (stable[i]),
      .evt_o    (evt[i]),
      .chg_o    (chg[i])
    );
    assign rise[i] = evt[i].rise;
    assign fall[i] = evt[i].fall;
  end

  always_ff @(posedge switclk or posedge switrst) begin
    if (switrst) changed_q <= 1'b0;
    else         changed_q <= |chg;
  end

  assign sw.sw_stable  = stable;
  assign sw.sw_rise    = rise;
  assign sw.sw_fall    = fall;
  assign sw.sw_changed = changed_q;
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_CYCLES=4.
module tb_switch_debounce;
  import switch_debounce_pkg::*;
  localparam int W  = SW_WIDTH;
  localparam int SC = SW_STABLE_CYCLES_SIM;

  logic switclk = 1'b0;
  logic switrst = 1'b1;

  switch_debounce_if #(.WIDTH(W)) sw_if();

  switch_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .switclk (switclk),
    .switrst (switrst),
    .sw      (sw_if)
  );

  always #5 switclk = ~switclk;

  int n_chk  = 0;
  int n_fail = 0;
  int g [W];
  logic [W-1:0] base, nb, r;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                         input logic [W-1:0] fa, input logic ch);
    chk({tag, " stable"}, sw_if.sw_stable, st);
    chk({tag, " rise"},   sw_if.sw_rise,   ri);
    chk({tag, " fall"},   sw_if.sw_fall,   fa);
    chk({tag, " chg"},    W'(sw_if.sw_changed), W'(ch));
  endtask

  task automatic tick();
    @(posedge switclk);
    @(negedge switclk);
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    switrst = 1'b1;
    sw_if.sw_raw = raw;
    repeat (2) tick();
    switrst = 1'b0;
  endtask

  initial begin
    // Reset state, with a high raw bit present during reset
    sw_if.sw_raw = 16'h0001;
    switrst = 1'b1;
    tick();
    chk_out("reset", '0, '0, '0, 1'b0);
    tick();
    switrst = 1'b0;

    // Single bit held: accept at edge 6, rise/changed at edge 7
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_out($sformatf("t1 e%0d", k), (k >= 6) ? 16'h0001 : 16'h0000,
              (k == 7) ? 16'h0001 : 16'h0000, '0, k == 7);
    end

    // Short 3-cycle pulse on bit 3 never accepted
    do_reset('0);
    for (int k = 1; k <= 10; k++) begin
      sw_if.sw_raw = (k <= 3) ? 16'h0008 : 16'h0000;
      tick();
      chk_out($sformatf("t2 e%0d", k), '0, '0, '0, 1'b0);
    end

    // Bit 5 bounce 1,0,1,1,...: accept at edge 8, rise at edge 9
    do_reset('0);
    for (int k = 1; k <= 10; k++) begin
      sw_if.sw_raw = (k == 2) ? 16'h0000 : 16'h0020;
      tick();
      chk_out($sformatf("t3 e%0d", k), (k >= 8) ? 16'h0020 : 16'h0000,
              (k == 9) ? 16'h0020 : 16'h0000, '0, k == 9);
    end

    // Multi-bit simultaneous rise then fall
    do_reset('0);
    sw_if.sw_raw = 16'hA5A5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_out($sformatf("t4r e%0d", k), (k >= 6) ? 16'hA5A5 : 16'h0000,
              (k == 7) ? 16'hA5A5 : 16'h0000, '0, k == 7);
    end
    sw_if.sw_raw = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_out($sformatf("t4f e%0d", k), (k >= 6) ? 16'h0000 : 16'hA5A5,
              '0, (k == 7) ? 16'hA5A5 : 16'h0000, k == 7);
    end

    // Reset mid-count clears everything asynchronously, no fall afterwards
    do_reset(16'hFFFF);
    repeat (8) tick();
    chk("t5 pre", sw_if.sw_stable, 16'hFFFF);
    sw_if.sw_raw = 16'h0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t5 e%0d", k), sw_if.sw_stable, 16'hFFFF);
    end
    #2 switrst = 1'b1;
    #1 chk_out("t5 async", '0, '0, '0, 1'b0);
    tick();
    switrst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_out($sformatf("t5 post e%0d", k), '0, '0, '0, 1'b0);
    end

    // Random sub-threshold bounce around a base, with periodic real changes
    do_reset('0);
    base = '0;
    for (int i = 0; i < W; i++) g[i] = 0;
    for (int seg = 0; seg < 10; seg++) begin
      for (int c = 0; c < 90; c++) begin
        for (int i = 0; i < W; i++) begin
          if (g[i] > 0) begin
            r[i] = ~base[i];
            g[i]--;
          end else begin
            r[i] = base[i];
            g[i] = $urandom_range(0, 3);
          end
        end
        sw_if.sw_raw = r;
        tick();
        chk($sformatf("t6 hold s%0d c%0d", seg, c), sw_if.sw_stable, base);
      end
      sw_if.sw_raw = base;
      for (int i = 0; i < W; i++) g[i] = 0;
      repeat (3) begin
        tick();
        chk($sformatf("t6 settle s%0d", seg), sw_if.sw_stable, base);
      end
      nb = W'($urandom);
      sw_if.sw_raw = nb;
      for (int k = 1; k <= 7; k++) begin
        tick();
        chk_out($sformatf("t6 chg s%0d e%0d", seg, k), (k >= 6) ? nb : base,
                (k == 7) ? (nb & ~base) : '0, (k == 7) ? (base & ~nb) : '0,
                (k == 7) && (nb != base));
      end
      base = nb;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter WIDTH, default 16, number of board switch inputs conditioned.
REQ-002 Parameter STABLE_CYCLES, default 1000000, consecutive clock cycles a synchronised input must differ from the accepted value before it is accepted; legal range 2 to 2^24.
REQ-003 switclk  input  1  system clock; all state updates on posedge.
REQ-004 switrst  input  1  reset switrst, asynchronous, active-high.
REQ-005 sw_raw  input  WIDTH  raw, asynchronous, bouncing switch levels from board pins.
REQ-006 sw_stable  output  WIDTH  debounced switch levels; drives the switch_rdata input of the switch read port.
REQ-007 sw_rise  output  WIDTH  one-cycle pulse per bit when that sw_stable bit changes 0->1.
REQ-008 sw_fall  output  WIDTH  one-cycle pulse per bit when that sw_stable bit changes 1->0.
REQ-009 sw_changed  output  1  one-cycle pulse when any sw_stable bit changes in that cycle.

Function
REQ-010 Each sw_raw bit SHALL pass through a two-flop synchroniser (sync1, sync2) before any other logic.
REQ-011 Each bit SHALL own an independent counter of width clog2(STABLE_CYCLES), with no sharing between bits.
REQ-012 Per bit, on each posedge: if sync2 equals the accepted value, counter <= 0.
REQ-013 Per bit, if sync2 differs and counter < STABLE_CYCLES-1, counter <= counter+1 and the accepted value holds.
REQ-014 Per bit, if sync2 differs and counter == STABLE_CYCLES-1, accepted value <= sync2 and counter <= 0 on the same edge.
REQ-015 A raw level change held steady SHALL appear on sw_stable exactly 2+STABLE_CYCLES posedges after the first edge that samples it.
REQ-016 A raw pulse or bounce run shorter than STABLE_CYCLES synchronised cycles SHALL NOT change sw_stable; any return to the accepted value restarts the count from 0.
REQ-017 The counter SHALL never wrap; its maximum reachable value is STABLE_CYCLES-1.
REQ-018 sw_rise, sw_fall and sw_changed SHALL be registered and asserted in the cycle immediately following the sw_stable update, for exactly one cycle.
REQ-019 Simultaneous acceptance on several bits SHALL set all matching rise/fall bits and a single-cycle sw_changed.
REQ-020 sw_stable SHALL be a registered output, glitch-free, and settled at least half a cycle before the negedge on which the downstream read port samples it.

Reset
REQ-021 While switrst is high, sync1, sync2, counters, sw_stable, sw_rise, sw_fall and sw_changed SHALL all be 0, independent of switclk.
REQ-022 Reset asserted mid-count SHALL discard partial counts; after release, a high raw bit requires the full 2+STABLE_CYCLES edges before sw_stable goes high.
REQ-023 The first posedge after switrst deasserts SHALL be a normal operating edge, with no extra idle cycle.

Structure
REQ-024 A shared package SHALL hold SW_WIDTH (16) and SW_STABLE_CYCLES_DEFAULT (1000000) plus a sim override value (4).
REQ-025 A sub-module debounce_bit, containing the synchroniser, counter, accepted-value flop and rise/fall detection, SHALL be instantiated WIDTH times by a generate loop.
REQ-026 The top level SHALL contain only the generate loop and the OR-reduction register for sw_changed.

Verification (STABLE_CYCLES=4)
REQ-027 Reset, then sw_raw=16'h0001 held -> sw_stable=16'h0001 at posedge 6; sw_rise[0] and sw_changed high at posedge 7 only.
REQ-028 Bit 3 toggled high for 3 cycles, then low -> sw_stable stays 16'h0000; no rise, fall or changed pulses.
REQ-029 Bit 5 bounces 1,0,1,1,1,1 on consecutive cycles -> count restarts after the 0; sw_stable[5] goes high 4 edges after the second synchronised 1.
REQ-030 sw_raw 16'h0000->16'hA5A5 in one cycle -> all eight bits accept on the same edge; sw_rise=16'hA5A5 and sw_changed pulse once.
REQ-031 Stable 16'hFFFF, then sw_raw=16'h0000 and switrst pulsed at posedge 3 of the count -> outputs 0 immediately; no sw_fall pulse afterwards.
REQ-032 Random bounce shorter than 4 cycles on all bits for 1000 cycles -> sw_stable constant; scoreboard checks REQ-015 latency on every accepted change.
